byte_serializer: RTL and testbench

Transmit-side counterpart of the 44-byte block input shift register. Accepts one parallel NBYTES-byte word through a valid/ready load handshake and emits it one byte per cycle on a valid/ready byte stream, most-significant byte first. Feeding its byte stream into the input shift register reproduces the original word bit-for-bit. It sits at the result/loopback path, serialising wide registers onto the 8-bit link.

---
 rtl/byte_serializer_if.sv | 24 ++
 rtl/byte_serializer.sv | 99 +++++++++
 tb/tb_byte_serializer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_serializer_if.sv
// byte_serializer_if: word-load handshake plus byte-stream handshake of the
// byte serializer. The slave modport is the serializer's view; the master
// modport is the view of whatever feeds words in and drains bytes out.
interface byte_serializer_if #(
    parameter int NBYTES = 44
);
    logic                  load_valid;
    logic                  load_ready;
    logic [NBYTES*8-1:0]   word_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [7:0]            byte_out;
    logic                  tx_done;

    modport master (
        output load_valid, word_in, byte_ready,
        input  load_ready, byte_valid, byte_out, tx_done
    );

    modport slave (
        input  load_valid, word_in, byte_ready,
        output load_ready, byte_valid, byte_out, tx_done
    );
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer: accepts one NBYTES-byte word and emits it MSB-first, one
// byte per cycle, on a valid/ready byte stream. Optional trailing XOR
// checksum byte is enabled by defining SERIALIZER_CHECKSUM_EN.
module byte_serializer #(
    parameter int NBYTES    = 44,
    parameter int COUNTBITS = 7
) (
    input  logic             clk,
    input  logic             rst,   // synchronous, active-low
    byte_serializer_if.slave bus
);
    localparam int W = NBYTES * 8;

`ifdef SERIALIZER_CHECKSUM_EN
    localparam logic [COUNTBITS-1:0] FRAME_LEN = COUNTBITS'(NBYTES + 1);
`else
    localparam logic [COUNTBITS-1:0] FRAME_LEN = COUNTBITS'(NBYTES);
`endif
    localparam logic [COUNTBITS-1:0] ONE = COUNTBITS'(1);

    logic [W-1:0]          data_q, data_d;
    logic [COUNTBITS-1:0]  remaining_q, remaining_d;
    logic                  tx_done_q, tx_done_d;
`ifdef SERIALIZER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  byte_valid;
    logic                  load_ready;
    logic                  load_accept;
    logic                  byte_xfer;
    logic [7:0]            byte_sel;

    // Handshake qualifiers and the byte currently presented on the stream.
    always_comb begin
        byte_valid  = (remaining_q != '0);
        // Accept a new word when idle, or when the last byte leaves this cycle.
        load_ready  = rst & ((remaining_q == '0) |
                             ((remaining_q == ONE) & bus.byte_ready));
        load_accept = bus.load_valid & load_ready;
        byte_xfer   = byte_valid & bus.byte_ready;
        byte_sel    = data_q[W-1 -: 8];
`ifdef SERIALIZER_CHECKSUM_EN
        // The final slot of a frame carries the accumulated checksum.
        if (remaining_q == ONE) begin
            byte_sel = csum_q;
        end
`endif
    end

    assign bus.byte_valid = byte_valid;
    assign bus.byte_out   = byte_valid ? byte_sel : 8'h00;
    assign bus.load_ready = load_ready;
    assign bus.tx_done    = tx_done_q;

    // Next-state: shift on transfer; a load in the same cycle overrides it.
    always_comb begin
        data_d      = data_q;
        remaining_d = remaining_q;
        tx_done_d   = 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (byte_xfer) begin
            data_d      = {data_q[W-9:0], 8'h00};
            remaining_d = remaining_q - ONE;
            tx_done_d   = (remaining_q == ONE);
`ifdef SERIALIZER_CHECKSUM_EN
            csum_d      = csum_q ^ data_q[W-1 -: 8];
`endif
        end
        if (load_accept) begin
            data_d      = bus.word_in;
            remaining_d = FRAME_LEN;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_d      = 8'h00;
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q      <= '0;
            remaining_q <= '0;
            tx_done_q   <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            data_q      <= data_d;
            remaining_q <= remaining_d;
            tx_done_q   <= tx_done_d;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed and randomized stimulus; a queue-of-bytes
// model of the frame in flight is compared against the DUT every cycle.
module tb_byte_serializer;
    localparam int NB = 44;
    localparam int CB = 7;
`ifdef SERIALIZER_CHECKSUM_EN
    localparam int FLEN = NB + 1;
`else
    localparam int FLEN = NB;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    byte_serializer_if #(.NBYTES(NB)) bus();

    byte_serializer #(.NBYTES(NB), .COUNTBITS(CB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 0;

    // Model: bytes still to be sent for the current frame, and tx_done.
    logic [7:0] mq[$];
    logic       m_done = 1'b0;

    // Monitor captures.
    logic [7:0] cap_b[$];
    int         cap_c[$];
    int         done_c[$];
    int         acc_c[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_b.delete(); cap_c.delete(); done_c.delete(); acc_c.delete();
    endtask

    // Expected i-th byte of the frame built from word w (MSB first, then checksum).
    function automatic logic [7:0] frame_byte(input logic [NB*8-1:0] w, input int i);
        logic [7:0] x;
        x = 8'h00;
        if (i < NB) return w[8*(NB-1-i) +: 8];
        for (int k = 0; k < NB; k++) x ^= w[8*k +: 8];
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model update at each clock edge.
    always @(posedge clk) begin
        logic lr, xf;
        logic [7:0] x;
        if (!rst) begin
            mq.delete();
            m_done = 1'b0;
        end else begin
            lr = (mq.size() == 0) || (mq.size() == 1 && bus.byte_ready);
            xf = (mq.size() != 0) && bus.byte_ready;
            m_done = xf && (mq.size() == 1);
            if (xf) void'(mq.pop_front());
            if (bus.load_valid && lr) begin
                mq.delete();
                x = 8'h00;
                for (int k = NB - 1; k >= 0; k--) begin
                    mq.push_back(bus.word_in[8*k +: 8]);
                    x ^= bus.word_in[8*k +: 8];
                end
`ifdef SERIALIZER_CHECKSUM_EN
                mq.push_back(x);
`endif
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_valid", 32'(bus.byte_valid), 32'(mq.size() != 0));
            chk("byte_out", 32'(bus.byte_out), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            chk("load_ready", 32'(bus.load_ready),
                32'(rst && (mq.size() == 0 || (mq.size() == 1 && bus.byte_ready))));
            chk("tx_done", 32'(bus.tx_done), 32'(m_done));
        end
    end

    // Transaction monitor.
    always @(negedge clk) begin
        if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
            cap_b.push_back(bus.byte_out);
            cap_c.push_back(cyc);
        end
        if (bus.tx_done === 1'b1) begin
            done_c.push_back(cyc);
            $display("cycle %0d: tx_done", cyc);
        end
        if (bus.load_valid === 1'b1 && bus.load_ready === 1'b1 && rst === 1'b1) begin
            acc_c.push_back(cyc);
            $display("cycle %0d: load accepted, top byte 0x%02h", cyc, bus.word_in[NB*8-1 -: 8]);
        end
    end

    initial begin
        logic [NB*8-1:0] w, wb;
        bit got;

        bus.load_valid = 1'b0;
        bus.byte_ready = 1'b0;
        bus.word_in    = '0;
        rst            = 1'b0;

        // Reset then idle.
        step();
        chk_en = 1;
        @(negedge clk);
        chk("rst_load_ready", 32'(bus.load_ready), 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("idle_byte_valid", 32'(bus.byte_valid), 32'h0);
        chk("idle_byte_out", 32'(bus.byte_out), 32'h0);
        chk("idle_tx_done", 32'(bus.tx_done), 32'h0);
        chk("idle_load_ready", 32'(bus.load_ready), 32'h1);

        // Single frame, byte k = k+1, byte_ready held high.
        step();
        clear_caps();
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'(k + 1);
        bus.word_in = w; bus.load_valid = 1'b1; bus.byte_ready = 1'b1;
        step();
        bus.load_valid = 1'b0;
        repeat (FLEN + 5) step();
        chk("single_count", cap_b.size(), FLEN);
        chk("single_dones", done_c.size(), 1);
        if (cap_b.size() == FLEN && acc_c.size() == 1 && done_c.size() == 1) begin
            chk("single_first", 32'(cap_b[0]), 32'h2C);
            chk("single_second", 32'(cap_b[1]), 32'h2B);
            chk("single_last_data", 32'(cap_b[NB-1]), 32'h01);
`ifdef SERIALIZER_CHECKSUM_EN
            chk("single_checksum", 32'(cap_b[NB]), 32'h2C);
`endif
            chk("single_latency", cap_c[0], acc_c[0] + 1);
            chk("single_contiguous", cap_c[FLEN-1] - cap_c[0], FLEN - 1);
            chk("single_done_time", done_c[0], cap_c[FLEN-1] + 1);
        end

        // Backpressure: byte_ready pattern 1,0,0,1,...
        step();
        clear_caps();
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'($urandom);
        bus.word_in = w; bus.load_valid = 1'b1; bus.byte_ready = 1'b0;
        step();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 2 * FLEN + 10; i++) begin
            bus.byte_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        bus.byte_ready = 1'b1;
        chk("bp_count", cap_b.size(), FLEN);
        chk("bp_dones", done_c.size(), 1);
        if (cap_b.size() == FLEN) begin
            for (int i = 0; i < FLEN; i++) chk("bp_byte", 32'(cap_b[i]), 32'(frame_byte(w, i)));
        end

        // Back-to-back: second word of 0x5A bytes held valid until accepted.
        step();
        clear_caps();
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'(k + 1);
        bus.word_in = w; bus.load_valid = 1'b1; bus.byte_ready = 1'b1;
        step();
        bus.word_in = {NB{8'h5A}};
        got = 0;
        for (int i = 0; i < FLEN + 10 && !got; i++) begin
            @(negedge clk);
            if (bus.load_ready) got = 1;
            step();
        end
        bus.load_valid = 1'b0;
        chk("b2b_accept_seen", 32'(got), 32'h1);
        repeat (FLEN + 5) step();
        chk("b2b_accepts", acc_c.size(), 2);
        chk("b2b_count", cap_b.size(), 2 * FLEN);
        chk("b2b_dones", done_c.size(), 2);
        if (acc_c.size() == 2 && cap_b.size() == 2 * FLEN) begin
            chk("b2b_accept_cycle", acc_c[1], cap_c[FLEN-1]);
            chk("b2b_first_5a", 32'(cap_b[FLEN]), 32'h5A);
            chk("b2b_no_gap", cap_c[FLEN], cap_c[FLEN-1] + 1);
        end

        // Load while busy is ignored.
        step();
        clear_caps();
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'($urandom);
        for (int k = 0; k < NB; k++) wb[8*k +: 8] = 8'($urandom);
        bus.word_in = w; bus.load_valid = 1'b1; bus.byte_ready = 1'b1;
        step();
        bus.load_valid = 1'b0;
        repeat (5) step();
        bus.word_in = wb; bus.load_valid = 1'b1;
        @(negedge clk);
        chk("busy_load_ready", 32'(bus.load_ready), 32'h0);
        step();
        bus.load_valid = 1'b0;
        repeat (FLEN + 5) step();
        chk("busy_accepts", acc_c.size(), 1);
        chk("busy_count", cap_b.size(), FLEN);
        if (cap_b.size() == FLEN) begin
            for (int i = 0; i < FLEN; i++) chk("busy_byte", 32'(cap_b[i]), 32'(frame_byte(w, i)));
        end

        // Reset mid-frame after 10 bytes.
        step();
        clear_caps();
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'($urandom);
        bus.word_in = w; bus.load_valid = 1'b1; bus.byte_ready = 1'b1;
        step();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 30 && cap_b.size() < 10; i++) step();
        chk("mid_bytes_before_rst", cap_b.size(), 10);
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_byte_valid", 32'(bus.byte_valid), 32'h0);
        repeat (5) step();
        chk("mid_rst_no_done", done_c.size(), 0);
        clear_caps();
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'($urandom);
        bus.word_in = w; bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        repeat (FLEN + 5) step();
        chk("post_rst_count", cap_b.size(), FLEN);
        chk("post_rst_dones", done_c.size(), 1);
        if (cap_b.size() == FLEN) begin
            for (int i = 0; i < FLEN; i++) chk("post_rst_byte", 32'(cap_b[i]), 32'(frame_byte(w, i)));
        end

        // Randomized traffic, checked by the per-cycle model compare.
        for (int i = 0; i < 4000; i++) begin
            if (!bus.load_valid || bus.load_ready) begin
                for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'($urandom);
                bus.word_in = w;
            end
            bus.load_valid = ($urandom_range(0, 3) == 0);
            bus.byte_ready = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 599) != 0);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        bus.load_valid = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
